// File: rtl/cdc_reset_pkg.sv
// Shared types and width helpers for the multi-channel reset sequencer.
package cdc_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_req_sync.sv
// STAGES-deep single-bit synchronizer with synchronous reset to RST_VAL.
module cdc_req_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_reset_sequencer.sv
// Reset sequencer: minimum hold, deassertion filter, then staggered release
// of active-low channel resets starting at first_ch.
module cdc_reset_sequencer
  import cdc_reset_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int STAGES      = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int FILTER      = 3,
  parameter int RELEASE_GAP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arst_req_n,
  input  logic [NUM_CH-1:0] sw_rst_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

  localparam int CW  = cnt_width(MIN_ASSERT, FILTER, RELEASE_GAP);
  localparam int CHW = $clog2(NUM_CH + 1);

  localparam logic [CW-1:0]  MIN_LAST  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0]  FILT_LAST = CW'(FILTER - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(RELEASE_GAP - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);

  logic              req_sync;
  state_e            state;
  logic [CW-1:0]     cnt;
  logic [CHW-1:0]    first_ch, next_ch, sw_k;
  logic [NUM_CH-1:0] rst_n_q, first_bit, next_bit, below_k;
  logic              done_q, sw_hit;

  cdc_req_sync #(.STAGES(STAGES), .RST_VAL(1'b0)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (arst_req_n),
    .q   (req_sync)
  );

  // One-hot selects for the channel being released and the sw-reset keep mask.
  always_comb begin
    first_bit = '0;
    next_bit  = '0;
    below_k   = '0;
    sw_k      = '0;
    sw_hit    = |sw_rst_i;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (sw_rst_i[i]) sw_k = CHW'(i);
    for (int i = 0; i < NUM_CH; i++) begin
      first_bit[i] = (CHW'(i) == first_ch);
      next_bit[i]  = (CHW'(i) == next_ch);
      below_k[i]   = (CHW'(i) < sw_k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      first_ch <= '0;
      next_ch  <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
    end else if (!req_sync && state != ST_HOLD) begin
      // External request outranks everything, including a same-cycle sw reset.
      state    <= ST_HOLD;
      cnt      <= '0;
      first_ch <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_HOLD: begin
          // A request during hold widens the scope to all channels but keeps the count.
          if (!req_sync) begin
            rst_n_q  <= '0;
            first_ch <= '0;
          end
          if (cnt == MIN_LAST && req_sync) begin
            state <= ST_FILTER;
            cnt   <= '0;
          end else if (cnt != MIN_LAST) begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FILTER: begin
          if (cnt == FILT_LAST) begin
            rst_n_q <= rst_n_q | first_bit;
            next_ch <= first_ch + CHW'(1);
            cnt     <= '0;
            state   <= (first_ch == LAST_CH) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_n_q <= rst_n_q | next_bit;
            next_ch <= next_ch + CHW'(1);
            cnt     <= '0;
            if (next_ch == LAST_CH) state <= ST_RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (sw_hit) begin
            rst_n_q  <= rst_n_q & below_k;
            first_ch <= sw_k;
            cnt      <= '0;
            state    <= ST_HOLD;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign state_o = state;

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Directed bench: power-up, glitch, filter restart, mid-release reassert,
// software resets, request/sw priority and a minimal-parameter instance.
module tb_cdc_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       arst_req_n;
  logic [3:0] sw_rst_i;
  logic [3:0] rst_n_o;
  logic       done_o;
  logic [1:0] state_o;

  logic       arst2;
  logic [0:0] sw2;
  logic [0:0] rst_n2;
  logic       done2;
  logic [1:0] state2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdc_reset_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .arst_req_n (arst_req_n),
    .sw_rst_i   (sw_rst_i),
    .rst_n_o    (rst_n_o),
    .done_o     (done_o),
    .state_o    (state_o)
  );

  cdc_reset_sequencer #(
    .NUM_CH(1), .STAGES(3), .MIN_ASSERT(1), .FILTER(1), .RELEASE_GAP(1)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .arst_req_n (arst2),
    .sw_rst_i   (sw2),
    .rst_n_o    (rst_n2),
    .done_o     (done2),
    .state_o    (state2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Check cycles c0..n-1 relative to a HOLD entry whose scope starts at channel f;
  // channels below f keep their value in pre.
  task automatic seq_check(input int f, input logic [3:0] pre, input int c0, input int n,
                           input bit with2);
    logic [3:0] er;
    logic       ed;
    logic [1:0] es;
    int         fin;
    fin = 19 + 8 * (3 - f);
    for (int c = c0; c < n; c++) begin
      for (int i = 0; i < 4; i++) er[i] = (i < f) ? pre[i] : (c >= 19 + 8 * (i - f));
      ed = (c >= fin + 1);
      es = (c < 16) ? 2'd0 : (c < 19) ? 2'd1 : (c < fin) ? 2'd2 : 2'd3;
      chk("rst_n", 32'(rst_n_o), 32'(er));
      chk("done", 32'(done_o), 32'(ed));
      chk("state", 32'(state_o), 32'(es));
      if (with2) begin
        chk("rst_n2", 32'(rst_n2), 32'(c >= 5));
        chk("done2", 32'(done2), 32'(c >= 6));
        chk("state2", 32'(state2), (c < 4) ? 32'd0 : (c == 4) ? 32'd1 : 32'd3);
      end
      step();
    end
  endtask

  // One-cycle request pulse from RUN; ends in the first HOLD cycle (3 cycles on).
  task automatic glitch();
    arst_req_n = 1'b0;
    step();
    arst_req_n = 1'b1;
    chk("glitch_keep1", 32'(rst_n_o), 32'hF);
    step();
    chk("glitch_keep2", 32'(rst_n_o), 32'hF);
    step();
    chk("glitch_drop", 32'(rst_n_o), 32'h0);
    chk("glitch_state", 32'(state_o), 32'd0);
    chk("glitch_done", 32'(done_o), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    arst_req_n = 1'b1;
    sw_rst_i   = 4'b0;
    arst2      = 1'b1;
    sw2        = 1'b0;
    repeat (3) step();
    chk("rst_rst_n", 32'(rst_n_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_rst_n2", 32'(rst_n2), 32'h0);
    rst = 1'b0;

    // Power-up, both instances.
    seq_check(0, 4'b0, 0, 45, 1'b1);

    // Short glitch in RUN: full sequence repeats.
    glitch();
    seq_check(0, 4'b0, 0, 45, 1'b0);

    // Filter restart: req_sync drops during the second FILTER cycle.
    glitch();
    seq_check(0, 4'b0, 0, 15, 1'b0);
    chk("fr_hold15", 32'(state_o), 32'd0);
    arst_req_n = 1'b0;
    step();
    arst_req_n = 1'b1;
    chk("fr_filt16", 32'(state_o), 32'd1);
    chk("fr_rst16", 32'(rst_n_o), 32'h0);
    step();
    chk("fr_filt17", 32'(state_o), 32'd1);
    chk("fr_rst17", 32'(rst_n_o), 32'h0);
    step();
    chk("fr_back", 32'(state_o), 32'd0);
    seq_check(0, 4'b0, 0, 45, 1'b0);

    // Reassert after channel 1 released.
    glitch();
    seq_check(0, 4'b0, 0, 28, 1'b0);
    arst_req_n = 1'b0;
    chk("mid_pre", 32'(rst_n_o), 32'h3);
    step();
    arst_req_n = 1'b1;
    chk("mid_29", 32'(rst_n_o), 32'h3);
    step();
    chk("mid_30", 32'(rst_n_o), 32'h3);
    step();
    chk("mid_clear", 32'(rst_n_o), 32'h0);
    chk("mid_state", 32'(state_o), 32'd0);
    seq_check(0, 4'b0, 0, 45, 1'b0);

    // Software reset of channels 1 and 2: lowest set index is 1.
    sw_rst_i = 4'b0110;
    step();
    sw_rst_i = 4'b0;
    chk("sw_vec", 32'(rst_n_o), 32'h1);
    seq_check(1, 4'b0001, 0, 37, 1'b0);

    // Software reset of the last channel only: FILTER goes straight to RUN.
    sw_rst_i = 4'b1000;
    step();
    sw_rst_i = 4'b0;
    chk("sw3_vec", 32'(rst_n_o), 32'h7);
    seq_check(3, 4'b0111, 0, 21, 1'b0);

    // Request and sw reset together: request wins; sw is ignored once in HOLD.
    arst_req_n = 1'b0;
    step();
    arst_req_n = 1'b1;
    step();
    sw_rst_i = 4'b0100;
    step();
    chk("prio_vec", 32'(rst_n_o), 32'h0);
    chk("prio_state", 32'(state_o), 32'd0);
    step();
    sw_rst_i = 4'b0;
    seq_check(0, 4'b0, 1, 45, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
